// File: rtl/chan_ctrl_pkg.sv
// rtl/chan_ctrl_pkg.sv - shared types, LFSR constants and reset-default config for the channel state controller
package chan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GOOD = 2'd1,
      ST_BAD  = 2'd2
   } chan_state_e;

   localparam logic [15:0] LFSR_POLY     = 16'hB400;
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   localparam logic [15:0] DEF_P_GB      = 16'h0148;
   localparam logic [15:0] DEF_P_BG      = 16'h1999;
   localparam int          DEF_MIN_DWELL = 1;

   // Right-shifting Galois step for x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/channel_state_controller_if.sv
// rtl/channel_state_controller_if.sv - symbol, config and statistics bus of the channel state controller
interface channel_state_controller_if #(
   parameter int DWELL_W = 8,
   parameter int CNT_W   = 16
);
   logic               enable;
   logic               sym_valid;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [15:0]        cfg_p_gb;
   logic [15:0]        cfg_p_bg;
   logic [DWELL_W-1:0] cfg_min_dwell;
   logic               clear_stats;
   logic               chan_state;
   logic               state_change;
   logic [CNT_W-1:0]   bad_sym_count;
   logic [CNT_W-1:0]   burst_count;

   modport master (
      output enable, sym_valid, cfg_valid, cfg_p_gb, cfg_p_bg, cfg_min_dwell, clear_stats,
      input  cfg_ready, chan_state, state_change, bad_sym_count, burst_count
   );

   modport slave (
      input  enable, sym_valid, cfg_valid, cfg_p_gb, cfg_p_bg, cfg_min_dwell, clear_stats,
      output cfg_ready, chan_state, state_change, bad_sym_count, burst_count
   );
endinterface

// File: rtl/chan_lfsr16.sv
// rtl/chan_lfsr16.sv - 16-bit Galois LFSR with advance enable, async reset to the seed
module chan_lfsr16
   import chan_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        adv_i,
   output logic [15:0] state_o
);

   logic [15:0] lfsr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= LFSR_SEED;
      end else if (adv_i) begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/channel_state_controller.sv
// rtl/channel_state_controller.sv - Gilbert-Elliott good/bad channel scheduler with burst statistics
// Optional macro CHAN_FORCE_EN adds force_en/force_bad ports that override chan_state.
module channel_state_controller
   import chan_ctrl_pkg::*;
#(
   parameter int DWELL_W = 8,
   parameter int CNT_W   = 16
) (
   input  logic clk,
   input  logic reset,
`ifdef CHAN_FORCE_EN
   input  logic force_en,
   input  logic force_bad,
`endif
   channel_state_controller_if.slave bus
);

   chan_state_e        state_q, state_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_inc;
   logic               change_q, change_d;
   logic [15:0]        p_gb_q, p_bg_q, thr;
   logic [DWELL_W-1:0] min_dwell_q;
   logic [CNT_W-1:0]   bad_cnt_q, burst_cnt_q;
   logic [15:0]        lfsr;
   logic               forced, bad_now, run_sym, fsm_sym, take;

`ifdef CHAN_FORCE_EN
   assign forced  = force_en;
   assign bad_now = force_en ? force_bad : (state_q == ST_BAD);
`else
   assign forced  = 1'b0;
   assign bad_now = (state_q == ST_BAD);
`endif

   assign run_sym   = bus.enable && bus.sym_valid && (state_q != ST_IDLE);
   assign fsm_sym   = run_sym && !forced;
   assign dwell_inc = (dwell_q == {DWELL_W{1'b1}}) ? dwell_q : dwell_q + DWELL_W'(1);
   assign thr       = (state_q == ST_BAD) ? p_bg_q : p_gb_q;
   // Decision uses the LFSR value before this symbol's advance
   assign take      = (dwell_inc >= min_dwell_q) && (lfsr <= thr);

   chan_lfsr16 u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .adv_i   (fsm_sym),
      .state_o (lfsr)
   );

   always_comb begin
      state_d  = state_q;
      dwell_d  = dwell_q;
      change_d = 1'b0;
      if (!bus.enable) begin
         state_d = ST_IDLE;
         dwell_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_GOOD;
               dwell_d = '0;
            end
            ST_GOOD, ST_BAD: begin
               if (fsm_sym) begin
                  if (take) begin
                     state_d  = (state_q == ST_GOOD) ? ST_BAD : ST_GOOD;
                     dwell_d  = '0;
                     change_d = 1'b1;
                  end else begin
                     dwell_d = dwell_inc;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               dwell_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         dwell_q  <= '0;
         change_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dwell_q  <= dwell_d;
         change_q <= change_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_gb_q      <= DEF_P_GB;
         p_bg_q      <= DEF_P_BG;
         min_dwell_q <= DWELL_W'(DEF_MIN_DWELL);
      end else if (bus.cfg_valid && (state_q == ST_IDLE)) begin
         p_gb_q      <= bus.cfg_p_gb;
         p_bg_q      <= bus.cfg_p_bg;
         min_dwell_q <= bus.cfg_min_dwell;
      end
   end

   // Clear wins over a same-cycle increment; both counters stick at all-ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bad_cnt_q   <= '0;
         burst_cnt_q <= '0;
      end else if (bus.clear_stats) begin
         bad_cnt_q   <= '0;
         burst_cnt_q <= '0;
      end else begin
         if (run_sym && bad_now && (bad_cnt_q != {CNT_W{1'b1}})) begin
            bad_cnt_q <= bad_cnt_q + CNT_W'(1);
         end
         if (change_d && (state_q == ST_GOOD) && (burst_cnt_q != {CNT_W{1'b1}})) begin
            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.cfg_ready     = (state_q == ST_IDLE);
   assign bus.chan_state    = !bad_now;
   assign bus.state_change  = change_q;
   assign bus.bad_sym_count = bad_cnt_q;
   assign bus.burst_count   = burst_cnt_q;

endmodule

// File: doc/channel_state_controller.md
Name: channel_state_controller

Overview:
- Gilbert-Elliott burst-error scheduler for the AWGN noise channel. Drives the channel's good/bad select (1 = good noise table, 0 = bad noise table) per symbol.
- A two-state Markov chain is driven by an internal LFSR, with configurable transition thresholds and a minimum dwell.
- Sits between the symbol-rate strobe of the transmit datapath and the noise channel. Exposes burst statistics to the test/readout logic.

Parameters:
DWELL_W, 8, width of the min-dwell config and the dwell counter
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
enable  input  1  run the chain; low forces IDLE
sym_valid  input  1  one-cycle strobe per channel symbol
cfg_valid  input  1  config offer
cfg_ready  output  1  config accept; high only in IDLE
cfg_p_gb  input  16  GOOD->BAD threshold
cfg_p_bg  input  16  BAD->GOOD threshold
cfg_min_dwell  input  DWELL_W  minimum symbols per state visit
clear_stats  input  1  synchronous clear of the statistics counters
chan_state  output  1  1 = good, 0 = bad; drives the channel state select
state_change  output  1  one-cycle pulse on a GOOD<->BAD change
bad_sym_count  output  CNT_W  symbols spent in BAD
burst_count  output  CNT_W  number of GOOD->BAD entries

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
  - FSM=IDLE, chan_state=1, state_change=0, counters=0, dwell=0.
  - cfg registers: p_gb=16'h0148, p_bg=16'h1999, min_dwell=1.
  - LFSR=16'hACE1.
- FSM states: IDLE, GOOD, BAD. chan_state=0 only in BAD.
- IDLE:
  - cfg_ready=1. On cfg_valid&&cfg_ready, all three cfg fields are latched in that cycle.
  - enable=1 -> GOOD next cycle, without waiting for sym_valid. dwell=0; no state_change pulse.
- Any state with enable=0 -> IDLE next cycle. dwell=0, LFSR holds, counters hold. BAD->IDLE does not pulse state_change.
- LFSR: 16-bit Galois, x^16+x^14+x^13+x^11+1, never zero. Advances once per sym_valid while in GOOD/BAD. Decisions use the pre-advance value L.
- On sym_valid in GOOD/BAD:
  - The current chan_state applies to this symbol.
  - d = dwell+1, saturating at 2^DWELL_W-1.
  - Transition fires iff d >= min_dwell && L <= threshold. Threshold is p_gb in GOOD and p_bg in BAD.
  - threshold=0 means never (L is nonzero); threshold=16'hFFFF means always.
  - On transition: the state flips next cycle, dwell <= 0, and state_change=1 for exactly that cycle (registered, aligned with the chan_state update).
  - Otherwise dwell <= d.
  - Every visit lasts at least max(1, min_dwell) symbols.
- Statistics:
  - bad_sym_count += 1 per sym_valid while chan_state=0.
  - burst_count += 1 per GOOD->BAD transition.
  - Both saturate at all-ones. clear_stats has priority over a same-cycle increment.
- sym_valid in IDLE is ignored. cfg_valid outside IDLE is ignored (cfg_ready=0).
- Reset mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
- Macro CHAN_FORCE_EN.
- Defined:
  - Adds ports force_en (in, 1) and force_bad (in, 1).
  - While force_en=1, chan_state = ~force_bad, combinationally overriding the FSM output.
  - FSM, dwell and LFSR are frozen (no advance). bad_sym_count counts forced-bad symbols. burst_count does not count. state_change=0.
- Undefined: no such ports; chan_state comes from the FSM only.

Decomposition:
- Package chan_ctrl_pkg holds:
  - the state enum (IDLE/GOOD/BAD);
  - LFSR polynomial mask 16'hB400 and seed 16'hACE1;
  - reset-default thresholds and min_dwell.
- One sub-module, chan_lfsr16: 16-bit Galois LFSR with advance enable and async reset to the seed.

Test Plan:
- enable=1, p_gb=0, 1000 sym_valid -> chan_state stays 1, bad_sym_count=0, burst_count=0, state_change never asserted.
- p_gb=p_bg=16'hFFFF, min_dwell=0, 10 sym_valid -> chan_state alternates each symbol; burst_count=5, bad_sym_count=5, 10 state_change pulses.
- p_gb=p_bg=16'hFFFF, min_dwell=4, 16 sym_valid -> runs of exactly 4 symbols; state_change one cycle after sym_valid #4, #8, #12, #16.
- cfg_valid while running -> cfg_ready=0, config unchanged. enable=0 -> IDLE next cycle, cfg_ready=1, new config latched in the handshake cycle.
- clear_stats asserted together with a BAD sym_valid -> bad_sym_count=0 next cycle. With CNT_W=4, 20 BAD symbols -> saturates at 15.
- reset pulse mid-BAD (no clock edge) -> chan_state=1, counters 0, cfg returns to defaults, LFSR reseeded; repeat a run and get an identical sequence.
